// File: rtl/atd_pkg.sv
// atd_pkg: FSM state type and default parameters shared by the ATD receiver
package atd_pkg;
    typedef enum logic {IDLE, RECV} atd_state_e;
    localparam int ATD_DATA_WIDTH     = 128;
    localparam int ATD_FIFO_DEPTH     = 4;
    localparam int ATD_MSB_FIRST      = 1;
    localparam int ATD_SAMPLE_EDGE    = 1;
    localparam int ATD_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/atd_word_fifo.sv
// atd_word_fifo: show-ahead word FIFO; a push into a full FIFO only lands when a pop frees a slot
module atd_word_fifo import atd_pkg::*; #(
    parameter int WIDTH = ATD_DATA_WIDTH,
    parameter int DEPTH = ATD_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/atd_rx_core.sv
// atd_rx_core: serial-to-parallel receiver for an asynchronous bit clock, with idle timeout and word FIFO
module atd_rx_core import atd_pkg::*; #(
    parameter int DATA_WIDTH     = ATD_DATA_WIDTH,
    parameter int FIFO_DEPTH     = ATD_FIFO_DEPTH,
    parameter int MSB_FIRST      = ATD_MSB_FIRST,
    parameter int SAMPLE_EDGE    = ATD_SAMPLE_EDGE,
    parameter int TIMEOUT_CYCLES = ATD_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ATD_clk,
    input  logic                          ATD_data,
    input  logic                          data_taken,
    output logic                          data_ready,
    output logic [DATA_WIDTH-1:0]         ATD_parallel,
    output logic                          overflow,
    output logic                          frame_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = $clog2(DATA_WIDTH+1);
    localparam int IW = $clog2(TIMEOUT_CYCLES+1);
    // ATD_clk chain resets to the post-edge level so reset release can never look like a sample edge
    localparam logic CK_RST = 1'(SAMPLE_EDGE != 0);
    logic ck_s1, ck_s2, ck_s3, d_s1, d_s2;
    logic edge_hit, word_done, full, empty;
    logic [DATA_WIDTH-1:0] shreg, shift_nxt;
    logic [BW-1:0] bit_cnt;
    logic [IW-1:0] idle_cnt;
    atd_state_e state;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {ck_s1, ck_s2, ck_s3} <= {3{CK_RST}};
            {d_s1, d_s2} <= '0;
        end else begin
            {ck_s1, ck_s2, ck_s3} <= {ATD_clk, ck_s1, ck_s2};
            {d_s1, d_s2} <= {ATD_data, d_s1};
        end
    assign edge_hit  = (SAMPLE_EDGE != 0) ? (ck_s2 & ~ck_s3) : (~ck_s2 & ck_s3);
    assign shift_nxt = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], d_s2} : {d_s2, shreg[DATA_WIDTH-1:1]};
    assign word_done = edge_hit && state == RECV && bit_cnt == BW'(DATA_WIDTH-1);
    assign data_ready = ~empty;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (word_done && full && !data_taken) overflow <= 1'b1;
            case (state)
                IDLE:
                    if (edge_hit) begin
                        shreg    <= shift_nxt;
                        bit_cnt  <= BW'(1);
                        idle_cnt <= '0;
                        state    <= RECV;
                    end
                RECV:
                    if (edge_hit) begin
                        idle_cnt <= '0;
                        shreg    <= word_done ? '0 : shift_nxt;
                        bit_cnt  <= word_done ? '0 : bit_cnt + BW'(1);
                        state    <= word_done ? IDLE : RECV;
                    end else if (idle_cnt == IW'(TIMEOUT_CYCLES-1)) begin
                        shreg       <= '0;
                        bit_cnt     <= '0;
                        idle_cnt    <= '0;
                        frame_error <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                default: state <= IDLE;
            endcase
        end
    atd_word_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_done),
        .pop   (data_taken),
        .din   (shift_nxt),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (ATD_parallel)
    );
endmodule

// File: doc/atd_rx_core.md
ATD_RX_CORE -- requirements
Module: atd_rx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 128: bits per assembled word, 8..256.
REQ-002 Parameter FIFO_DEPTH, default 4: words buffered, power of 2, >=2.
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in ATD_parallel[DATA_WIDTH-1]; 0 means it lands in bit 0.
REQ-004 Parameter SAMPLE_EDGE, default 1: 1 samples on ATD_clk rising edge; 0 samples on falling edge.
REQ-005 Parameter TIMEOUT_CYCLES, default 64: number of idle clk cycles that abort a partial word.
REQ-006 Port clk, input, 1: single system clock; all state is on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port ATD_clk, input, 1: asynchronous serial bit clock.
REQ-009 Port ATD_data, input, 1: asynchronous serial data.
REQ-010 Port data_taken, input, 1: consumer pop strobe.
REQ-011 Port data_ready, output, 1: high while the FIFO is non-empty.
REQ-012 Port ATD_parallel, output, DATA_WIDTH: FIFO head word, show-ahead.
REQ-013 Port overflow, output, 1: sticky; a completed word was dropped.
REQ-014 Port frame_error, output, 1: one-cycle pulse when a partial word is discarded on timeout.
REQ-015 Port fifo_count, output, $clog2(FIFO_DEPTH)+1: number of words held.

Function
REQ-016 ATD_clk and ATD_data shall each pass through a 2-flop synchronizer; a third flop on the ATD_clk path shall hold its previous value for edge detection.
REQ-017 A selected edge (per SAMPLE_EDGE) shall shift the synchronized data bit into the shift register at the following clk edge, i.e. the 3rd clk edge after the ATD_clk transition.
REQ-018 FSM states:
- IDLE: bit count 0; a selected edge shifts in a bit and moves to RECV.
- RECV: each selected edge increments the bit count.
REQ-019 When the DATA_WIDTH-th bit shifts in, the complete word (including that bit) shall be written to the FIFO on the same clk edge, the bit count shall clear, and the FSM shall return to IDLE.
REQ-020 data_ready and the new word shall be visible the cycle after the write.
REQ-021 In RECV, an idle counter shall count cycles with no selected edge and clear on every selected edge.
REQ-022 When the idle counter reaches TIMEOUT_CYCLES, the block shall discard the partial word, pulse frame_error for 1 cycle, and enter IDLE.
REQ-023 data_taken with data_ready high shall pop the head at the clk edge; data_taken with data_ready low shall be ignored.
REQ-024 Simultaneous write and pop shall both occur, including when the FIFO is full; fifo_count shall be unchanged.
REQ-025 A write when the FIFO is full with no pop shall drop the new word, set overflow, and leave FIFO contents unchanged.
REQ-026 FIFO pointers shall wrap modulo FIFO_DEPTH; fifo_count shall never exceed FIFO_DEPTH.

Reset
REQ-027 Asserting rst shall immediately clear: synchronizers, edge flop, shift register, bit and idle counters, FIFO pointers and count, overflow and frame_error; FSM goes to IDLE.
REQ-028 During reset, data_ready=0, ATD_parallel=0 and fifo_count=0; a partial word in progress at reset shall be lost.
REQ-029 The synchronizer edge flop shall reset to the inactive level of the selected edge, so that no spurious edge occurs when rst releases while ATD_clk is high.

Structure
REQ-030 Package atd_pkg shall hold the FSM state enum (IDLE, RECV) and the default parameter constants.
REQ-031 The FIFO shall be sub-module atd_word_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count, head).

Verification
REQ-032 With DATA_WIDTH=8 and MSB_FIRST=1, send bits 0,0,0,1,1,1,1,0 -> data_ready=1 and ATD_parallel=8'h1E within 4 clk after the last edge.
REQ-033 Same stimulus with MSB_FIRST=0 -> ATD_parallel=8'h78; with SAMPLE_EDGE=0 and falling-edge stimulus -> 8'h1E.
REQ-034 With FIFO_DEPTH=4, send 5 words 8'h01..8'h05 with no pops -> overflow=1 and fifo_count=4; four pops return 01,02,03,04 and then data_ready=0.
REQ-035 Send 3 bits then idle for 64 clk -> frame_error pulses once and fifo_count stays 0; next word 8'hC3 is received intact.
REQ-036 FIFO full plus a completing word plus data_taken on the same cycle -> overflow stays 0, fifo_count stays 4, and the new word appears last.
REQ-037 Assert rst after 5 bits -> all outputs 0; after release, a full word 8'h5A is received correctly.
